// File: rtl/core_pkg.sv
// Shared definitions for the writeback/retire slice: result width, the
// architectural zero register and the result entry carried through the FIFO.
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] val;
    } wb_entry_t;

    // A retiring entry only writes the register file when it names a real register
    function automatic logic retire_writes(input logic [4:0] rd);
        return rd != REG_ZERO;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Dual-push, single-pop circular result buffer. When both pushes are used in
// the same cycle, the first entry lands at the write pointer and the second
// one slot after it, preserving arrival order. Pointers wrap modulo DEPTH and
// count is one bit wider so a full buffer is distinguishable from empty.
module wb_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_first,
    input  wb_entry_t       first_entry,
    input  logic            push_second,
    input  wb_entry_t       second_entry,
    input  logic            pop,
    output wb_entry_t       head,
    output logic [PTRW:0]   count
);

    wb_entry_t       mem [DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [PTRW-1:0] wr_ptr_plus1;
    logic [PTRW:0]   count_next;

    assign wr_ptr_plus1 = wr_ptr + PTRW'(1);
    assign head         = mem[rd_ptr];
    assign count_next   = count + (PTRW+1)'(push_first) + (PTRW+1)'(push_second)
                          - (PTRW+1)'(pop);

    // Storage writes; contents are don't-care until a push fills a slot
    always_ff @(posedge clk) begin
        if (push_first) begin
            mem[wr_ptr] <= first_entry;
        end
        if (push_second) begin
            mem[wr_ptr_plus1] <= second_entry;
        end
    end

    // Pointer and occupancy bookkeeping, cleared by reset to discard buffered results
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_first && push_second) begin
                wr_ptr <= wr_ptr + PTRW'(2);
            end else if (push_first) begin
                wr_ptr <= wr_ptr_plus1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTRW'(1);
            end
            count <= count_next;
        end
    end

endmodule

// File: rtl/writeback_sb.sv
// Writeback and retire stage. Accepts results from the load unit and the ALU,
// buffers them in arrival order and retires one per cycle into the register
// file write port, reporting the retired register on lastRd for the fetch-side
// scoreboard. Load has priority when only one slot is free.
// Optional build macro WB_BYPASS_EN: a lone result arriving at an empty buffer
// retires at its own accept edge instead of passing through the FIFO.
module writeback_sb #(
    parameter int XLEN  = core_pkg::XLEN,
    parameter int DEPTH = 4,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ldValid,
    input  logic [4:0]       ldRd,
    input  logic [XLEN-1:0]  ldVal,
    output logic             ldReady,
    input  logic             aluValid,
    input  logic [4:0]       aluRd,
    input  logic [XLEN-1:0]  aluVal,
    output logic             aluReady,
    output logic             rfWe,
    output logic [4:0]       rfAddr,
    output logic [XLEN-1:0]  rfData,
    output logic [4:0]       lastRd,
    output logic [PTRW:0]    count
);

    core_pkg::wb_entry_t ld_entry;
    core_pkg::wb_entry_t alu_entry;
    core_pkg::wb_entry_t first_entry;
    core_pkg::wb_entry_t second_entry;
    core_pkg::wb_entry_t head;
    logic [PTRW:0]       free_slots;
    logic                ld_xfer;
    logic                alu_xfer;
    logic                push_first;
    logic                push_second;
    logic                pop;
`ifdef WB_BYPASS_EN
    logic                bypass_valid;
    core_pkg::wb_entry_t bypass_entry;
`endif

    // Readiness comes only from the registered occupancy, so a pop never frees a slot early
    assign free_slots = (PTRW+1)'(DEPTH) - count;
    assign ldReady    = free_slots >= (PTRW+1)'(1);
    assign aluReady   = free_slots >= (PTRW+1)'(2);

    assign ld_xfer  = ldValid && ldReady;
    assign alu_xfer = aluValid && aluReady;
    assign pop      = count != '0;

    assign ld_entry.rd   = ldRd;
    assign ld_entry.val  = ldVal;
    assign alu_entry.rd  = aluRd;
    assign alu_entry.val = aluVal;

    // Order the accepted results into FIFO slots: load first, ALU second
    always_comb begin
        push_first   = 1'b0;
        push_second  = 1'b0;
        first_entry  = ld_entry;
        second_entry = alu_entry;
`ifdef WB_BYPASS_EN
        bypass_valid = 1'b0;
        bypass_entry = ld_entry;
        if (count == '0 && (ld_xfer || alu_xfer)) begin
            bypass_valid = 1'b1;
            bypass_entry = ld_xfer ? ld_entry : alu_entry;
            if (ld_xfer && alu_xfer) begin
                push_first  = 1'b1;
                first_entry = alu_entry;
            end
        end else begin
            push_first  = ld_xfer || alu_xfer;
            first_entry = ld_xfer ? ld_entry : alu_entry;
            push_second = ld_xfer && alu_xfer;
        end
`else
        push_first  = ld_xfer || alu_xfer;
        first_entry = ld_xfer ? ld_entry : alu_entry;
        push_second = ld_xfer && alu_xfer;
`endif
    end

    wb_fifo #(
        .DEPTH (DEPTH),
        .PTRW  (PTRW)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_first   (push_first),
        .first_entry  (first_entry),
        .push_second  (push_second),
        .second_entry (second_entry),
        .pop          (pop),
        .head         (head),
        .count        (count)
    );

    // Registered retire port; address and data hold when nothing retires
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rfWe   <= 1'b0;
            rfAddr <= '0;
            rfData <= '0;
            lastRd <= '0;
        end else if (pop) begin
            rfWe   <= core_pkg::retire_writes(head.rd);
            rfAddr <= head.rd;
            rfData <= head.val;
            lastRd <= head.rd;
`ifdef WB_BYPASS_EN
        end else if (bypass_valid) begin
            rfWe   <= core_pkg::retire_writes(bypass_entry.rd);
            rfAddr <= bypass_entry.rd;
            rfData <= bypass_entry.val;
            lastRd <= bypass_entry.rd;
`endif
        end else begin
            rfWe   <= 1'b0;
            lastRd <= '0;
        end
    end

endmodule

// File: tb/tb_writeback_sb.sv
// Self-checking bench for writeback_sb. A queue of outstanding results is the
// reference: each edge retires the oldest queued result, then appends whatever
// the producers handed over, with acceptance decided from the queue's free room.
module tb_writeback_sb;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int PTRW  = 2;

    logic             clk;
    logic             reset;
    logic             ldValid;
    logic [4:0]       ldRd;
    logic [XLEN-1:0]  ldVal;
    logic             ldReady;
    logic             aluValid;
    logic [4:0]       aluRd;
    logic [XLEN-1:0]  aluVal;
    logic             aluReady;
    logic             rfWe;
    logic [4:0]       rfAddr;
    logic [XLEN-1:0]  rfData;
    logic [4:0]       lastRd;
    logic [PTRW:0]    count;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
    } ref_t;

    ref_t        model_q[$];
    logic        exp_we;
    logic [4:0]  exp_last;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    int          check_count;
    int          error_count;

    writeback_sb #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .PTRW  (PTRW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ldValid  (ldValid),
        .ldRd     (ldRd),
        .ldVal    (ldVal),
        .ldReady  (ldReady),
        .aluValid (aluValid),
        .aluRd    (aluRd),
        .aluVal   (aluVal),
        .aluReady (aluReady),
        .rfWe     (rfWe),
        .rfAddr   (rfAddr),
        .rfData   (rfData),
        .lastRd   (lastRd),
        .count    (count)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkRetirePort();
        checkOutput("rfWe",   32'(rfWe),   32'(exp_we));
        checkOutput("lastRd", 32'(lastRd), 32'(exp_last));
        checkOutput("rfAddr", 32'(rfAddr), 32'(exp_addr));
        checkOutput("rfData", 32'(rfData), exp_data);
        checkOutput("count",  32'(count),  32'(model_q.size()));
    endtask

    // One clock of traffic: drive at negedge, check readiness, then check the edge result
    task automatic applyStimulus(input logic lv, input logic [4:0] lrd, input logic [31:0] lval,
                                 input logic av, input logic [4:0] ard, input logic [31:0] aval,
                                 output logic ld_taken, output logic alu_taken);
        int   free_slots;
        logic exp_ld_rdy;
        logic exp_alu_rdy;
        logic did_pop;
        logic ld_skip;
        logic alu_skip;
        ref_t popped;
        @(negedge clk);
        ldValid  = lv;
        ldRd     = lrd;
        ldVal    = lval;
        aluValid = av;
        aluRd    = ard;
        aluVal   = aval;
        free_slots  = DEPTH - model_q.size();
        exp_ld_rdy  = free_slots >= 1;
        exp_alu_rdy = free_slots >= 2;
        #1;
        checkOutput("ldReady",  32'(ldReady),  32'(exp_ld_rdy));
        checkOutput("aluReady", 32'(aluReady), 32'(exp_alu_rdy));
        ld_taken  = lv && exp_ld_rdy;
        alu_taken = av && exp_alu_rdy;
        @(posedge clk);
        #1;
        did_pop  = 1'b0;
        ld_skip  = 1'b0;
        alu_skip = 1'b0;
        popped   = '{rd: 5'd0, val: 32'd0};
        if (model_q.size() > 0) begin
            popped  = model_q.pop_front();
            did_pop = 1'b1;
        end
`ifdef WB_BYPASS_EN
        else if (ld_taken || alu_taken) begin
            did_pop  = 1'b1;
            ld_skip  = ld_taken;
            alu_skip = alu_taken && !ld_taken;
            popped   = ld_taken ? '{rd: lrd, val: lval} : '{rd: ard, val: aval};
        end
`endif
        if (ld_taken && !ld_skip) begin
            model_q.push_back('{rd: lrd, val: lval});
        end
        if (alu_taken && !alu_skip) begin
            model_q.push_back('{rd: ard, val: aval});
        end
        if (did_pop) begin
            exp_we   = popped.rd != 5'd0;
            exp_last = popped.rd;
            exp_addr = popped.rd;
            exp_data = popped.val;
        end else begin
            exp_we   = 1'b0;
            exp_last = 5'd0;
        end
        checkRetirePort();
    endtask

    task automatic idleCycles(input int n);
        logic lt;
        logic at;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, lt, at);
        end
    endtask

    // Randomised producers that hold their rd/value while waiting for ready
    task automatic runTraffic(input int cycles, input int valid_pct);
        logic        lv;
        logic        av;
        logic [4:0]  lrd;
        logic [4:0]  ard;
        logic [31:0] lval;
        logic [31:0] aval;
        logic        lt;
        logic        at;
        logic        ld_hold;
        logic        alu_hold;
        ld_hold  = 1'b0;
        alu_hold = 1'b0;
        lv = 1'b0; av = 1'b0; lrd = '0; ard = '0; lval = '0; aval = '0;
        for (int i = 0; i < cycles; i++) begin
            if (!ld_hold) begin
                lv   = $urandom_range(0, 99) < valid_pct;
                lrd  = 5'($urandom);
                lval = $urandom;
            end
            if (!alu_hold) begin
                av   = $urandom_range(0, 99) < valid_pct;
                ard  = 5'($urandom);
                aval = $urandom;
            end
            applyStimulus(lv, lrd, lval, av, ard, aval, lt, at);
            ld_hold  = lv && !lt;
            alu_hold = av && !at;
        end
    endtask

    task automatic clearModel();
        model_q.delete();
        exp_we   = 1'b0;
        exp_last = 5'd0;
        exp_addr = 5'd0;
        exp_data = 32'd0;
    endtask

    logic lt_main;
    logic at_main;

    initial begin
        check_count = 0;
        error_count = 0;
        reset    = 1'b0;
        ldValid  = 1'b0;
        ldRd     = '0;
        ldVal    = '0;
        aluValid = 1'b0;
        aluRd    = '0;
        aluVal   = '0;
        clearModel();

        #12;
        checkRetirePort();
        @(negedge clk);
        reset = 1'b1;

        // Quiet period after reset release
        idleCycles(10);

        // Single ALU result, then its retire and the following empty edge
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234, lt_main, at_main);
        idleCycles(2);

        // Simultaneous load and ALU results retire load first
        applyStimulus(1'b1, 5'd3, 32'hAA, 1'b1, 5'd4, 32'hBB, lt_main, at_main);
        idleCycles(3);

        // Both producers always valid: occupancy climbs and ALU backs off at one free slot
        runTraffic(12, 100);
        idleCycles(5);

        // Result for x0 is consumed without a register-file write
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, lt_main, at_main);
        idleCycles(2);

        // Build up three buffered results, then reset in the middle of a cycle
        applyStimulus(1'b1, 5'd10, 32'h10, 1'b1, 5'd11, 32'h11, lt_main, at_main);
        applyStimulus(1'b1, 5'd12, 32'h12, 1'b1, 5'd13, 32'h13, lt_main, at_main);
        @(negedge clk);
        ldValid  = 1'b0;
        aluValid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        clearModel();
        checkRetirePort();
        @(negedge clk);
        reset = 1'b1;

        // Traffic after the reset retires normally
        applyStimulus(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, lt_main, at_main);
        idleCycles(2);

        // Mixed random traffic
        runTraffic(300, 60);
        idleCycles(6);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
